// File: rtl/multiword_addsub_seq.sv
`default_nettype none
// ============================================================================
// Module   : multiword_addsub_seq
// Brief    : Multi-precision add/subtract sequencer, one WIDTH-bit limb per
//            transfer (LS limb first) with carry/borrow chained across limbs.
// Revision : 1.0  initial release
// ============================================================================
module multiword_addsub_seq #(
  parameter int WIDTH = 8,
  parameter int LIMBS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_last,
  output logic             out_carry,
  output logic             out_overflow,
  output logic             busy
);

  localparam int IDX_W = (LIMBS > 1) ? $clog2(LIMBS) : 1;
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(LIMBS - 1);

  logic [IDX_W-1:0] r_idx;
  logic             r_mode;
  logic             r_carry;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_sum;
  logic             r_out_last;
  logic             r_out_carry;
  logic             r_out_overflow;

  logic             w_accept;
  logic             w_first;
  logic             w_final;
  logic             w_mode;
  logic             w_cin;
  logic [WIDTH-1:0] w_bm;
  logic [WIDTH:0]   w_full;
  logic             w_ovf;

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_first  = (r_idx == '0);
  assign w_final  = (r_idx == c_last_idx);

  // Limb 0 takes mode and carry-in straight from the port; later limbs use the latched copies.
  assign w_mode = w_first ? in_mode : r_mode;
  assign w_cin  = w_first ? in_mode : r_carry;
  assign w_bm   = w_mode ? ~in_b : in_b;
  assign w_full = {1'b0, in_a} + {1'b0, w_bm} + {{WIDTH{1'b0}}, w_cin};
  assign w_ovf  = (in_a[WIDTH-1] == w_bm[WIDTH-1]) && (w_full[WIDTH-1] != in_a[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx          <= '0;
      r_mode         <= 1'b0;
      r_carry        <= 1'b0;
      r_out_valid    <= 1'b0;
      r_out_sum      <= '0;
      r_out_last     <= 1'b0;
      r_out_carry    <= 1'b0;
      r_out_overflow <= 1'b0;
    end else if (w_accept) begin
      r_idx          <= w_final ? '0 : r_idx + 1'b1;
      r_carry        <= w_full[WIDTH];
      if (w_first) begin
        r_mode <= in_mode;
      end
      r_out_valid    <= 1'b1;
      r_out_sum      <= w_full[WIDTH-1:0];
      r_out_last     <= w_final;
      r_out_carry    <= w_final && w_full[WIDTH];
      r_out_overflow <= w_final && w_ovf;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid    = r_out_valid;
  assign out_sum      = r_out_sum;
  assign out_last     = r_out_last;
  assign out_carry    = r_out_carry;
  assign out_overflow = r_out_overflow;
  assign busy         = (r_idx != '0);

endmodule
`default_nettype wire

// File: tb/tb_multiword_addsub_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_multiword_addsub_seq
// Brief    : Scoreboard bench for multiword_addsub_seq using a full-word model.
// Revision : 1.0  initial release
// ============================================================================
module tb_multiword_addsub_seq;

  localparam int W = 8;
  localparam int L = 4;
  localparam int N = W * L;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         last;
    logic         carry;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_mode = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_sum;
  logic         out_last;
  logic         out_carry;
  logic         out_overflow;
  logic         busy;

  multiword_addsub_seq #(.WIDTH(W), .LIMBS(L)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_mode      (in_mode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_last     (out_last),
    .out_carry    (out_carry),
    .out_overflow (out_overflow),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_out   = 0;
  int   n_stall = 0;
  int   cyc     = 0;
  int   stall_start = -100;
  int   acc_cyc = 0;
  int   pkt_cycles = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream backpressure window of three cycles starting at stall_start.
  always @(posedge clk) begin
    #1;
    out_ready = !((cyc >= stall_start) && (cyc < stall_start + 3));
  end

  exp_t             e_mon;
  logic             stalled_prev = 1'b0;
  logic [W+2:0]     held = '0;

  always @(negedge clk) begin
    if (rst) begin
      stalled_prev = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        if (sb.size() == 0) begin
          check("spurious_out", {63'd0, out_valid}, 64'd0);
        end else begin
          e_mon = sb.pop_front();
          check("sum", {56'd0, out_sum}, {56'd0, e_mon.sum});
          check("last_carry_ovf", {61'd0, out_last, out_carry, out_overflow},
                {61'd0, e_mon.last, e_mon.carry, e_mon.ovf});
        end
      end
      if (out_valid && !out_ready) begin
        n_stall++;
        check("in_ready_stall", {63'd0, in_ready}, 64'd0);
        if (stalled_prev)
          check("hold_stable", {53'd0, out_sum, out_last, out_carry, out_overflow}, {53'd0, held});
        held = {out_sum, out_last, out_carry, out_overflow};
        stalled_prev = 1'b1;
      end else begin
        stalled_prev = 1'b0;
      end
    end
  end

  task automatic send_limb(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic m, input exp_t e);
    int   t;
    logic done;
    t = 0;
    done = 1'b0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_mode = m;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        done = 1'b1;
        acc_cyc = cyc;
      end
      @(posedge clk);
      #1;
      t++;
      if (!done && t > 50) begin
        check("accept_timeout", {63'd0, in_ready}, 64'd1);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    in_a = W'($urandom);
    in_b = W'($urandom);
    in_mode = 1'($urandom);
  endtask

  task automatic send_packet(input logic [N-1:0] A, input logic [N-1:0] B,
                             input logic m, input logic zero_upper_mode, input int gap);
    logic [N:0]   full;
    logic [N-1:0] bm;
    logic         ovf;
    exp_t         e;
    int           first_cyc;
    bm   = m ? ~B : B;
    full = {1'b0, A} + {1'b0, bm} + (N+1)'(m);
    ovf  = (A[N-1] == bm[N-1]) && (full[N-1] != A[N-1]);
    first_cyc = 0;
    for (int i = 0; i < L; i++) begin
      e.sum   = full[i*W +: W];
      e.last  = (i == L-1);
      e.carry = e.last ? full[N] : 1'b0;
      e.ovf   = e.last ? ovf : 1'b0;
      send_limb(A[i*W +: W], B[i*W +: W], (i == 0) ? m : (zero_upper_mode ? 1'b0 : m), e);
      if (i == 0) first_cyc = acc_cyc;
      if (gap > 0 && i < L-1) begin
        for (int g = 0; g < gap; g++) begin
          @(posedge clk);
          #1;
        end
        check("busy_gap", {63'd0, busy}, 64'd1);
      end
    end
    pkt_cycles = acc_cyc - first_cyc;
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while ((sb.size() != 0 || out_valid) && t < 30) begin
      @(posedge clk);
      #1;
      t++;
    end
    check({tag, "_drained"}, 64'(sb.size()), 64'd0);
    check({tag, "_busy_idle"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    exp_t dummy;
    dummy = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {52'd0, out_valid, out_sum, out_last, out_carry, out_overflow, busy}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: plain add, carry ripples into limb 1
    send_packet(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 0);
    check("s1_throughput", 64'(pkt_cycles), 64'd3);
    @(negedge clk);
    #1;
    check("s1_latency", 64'(sb.size()), 64'd0);
    drain("s1");

    // 2: 0 - 1 borrows all the way through
    send_packet(32'h00000000, 32'h00000001, 1'b1, 1'b0, 0);
    drain("s2");

    // 3: signed overflow into the sign bit
    send_packet(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 0);
    drain("s3");

    // 4: mode latched on limb 0, upper limbs drive in_mode=0
    send_packet(32'h00000005, 32'h00000003, 1'b1, 1'b1, 0);
    drain("s4");

    // 5: backpressure mid-packet, then the same packet with input gaps
    n_stall = 0;
    n_out = 0;
    stall_start = cyc + 2;
    send_packet(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 0);
    drain("s5a");
    check("s5_stall_seen", {63'd0, (n_stall >= 3)}, 64'd1);
    check("s5_out_count", 64'(n_out), 64'd4);
    send_packet(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 2);
    drain("s5b");

    // 6: reset after two limbs, then a fresh packet
    send_limb(8'hFF, 8'h01, 1'b0, dummy);
    send_limb(8'hFF, 8'h00, 1'b0, dummy);
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("s6_busy_after_rst", {63'd0, busy}, 64'd0);
    check("s6_valid_after_rst", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1;
    send_packet(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 0);
    drain("s6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
